// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: consumer-side controller for the team FIFO.
// Issues credit-limited pops, captures returned words into a small local
// buffer and presents the head word downstream on a valid/ready handshake.
// A drain command pops until the FIFO is empty and then pulses drain_done.
module fifo_pop_ctrl #(
    parameter int BITNUMBER = 6,
    parameter int OUT_DEPTH = 4,
    parameter int ERR_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 drain,
    input  logic                 fifo_empty,
    input  logic                 fifo_pause,
    input  logic                 fifo_valid_read,
    input  logic [BITNUMBER-1:0] fifo_data,
    input  logic                 fifo_rd_error,
    output logic                 fifo_rd,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 drain_done,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_count
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_OCC  = (CW+1)'(OUT_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(OUT_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STOP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [BITNUMBER-1:0] buf_mem [OUT_DEPTH];
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        count_reg, in_flight_reg;
    logic                 ignore_reg;
    logic                 fifo_rd_reg;
    logic [ERR_W-1:0]     err_count_reg;

    logic                 capture, write_en, accept, dec_flight, pop_next;
    logic [CW:0]          occupancy;

    // The first edge after reset release ignores any stale read return.
    assign capture    = fifo_valid_read & ~ignore_reg;
    assign accept     = valid_out & ready_in;
    // Credit guarantees room; the full check only protects stored data from a misbehaving FIFO.
    assign write_en   = capture & ((count_reg != DEPTH_CNT) | accept);
    assign dec_flight = capture & (in_flight_reg != '0);
    assign occupancy  = {1'b0, count_reg} + {1'b0, in_flight_reg} + {{CW{1'b0}}, fifo_rd_reg};

    // A pop is never issued right after another, so a lagging empty flag cannot cause a pop on empty.
    assign pop_next = (((state_reg == RUN) && !fifo_pause) || (state_reg == DRAIN))
                      && !fifo_empty && !fifo_rd_reg && (occupancy < DEPTH_OCC);

    assign fifo_rd    = fifo_rd_reg;
    assign valid_out  = (count_reg != '0);
    assign data_out   = buf_mem[rd_ptr_reg];
    assign busy       = (state_reg != IDLE);
    assign drain_done = (state_reg == DONE);
    assign err_count  = err_count_reg;

    // State register plus the one-cycle post-reset ignore flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            ignore_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            ignore_reg <= 1'b0;
        end
    end

    // Next-state logic; drain is only honoured outside DRAIN/DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (drain) state_next = DRAIN;
                   else if (enable) state_next = RUN;
            RUN:   if (drain) state_next = DRAIN;
                   else if (!enable) state_next = STOP;
            STOP:  if (drain) state_next = DRAIN;
                   else if ((in_flight_reg == '0) && !fifo_rd_reg) state_next = IDLE;
            DRAIN: if (fifo_empty && (in_flight_reg == '0) && !fifo_rd_reg) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered pop request and outstanding-pop credit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_rd_reg   <= 1'b0;
            in_flight_reg <= '0;
        end else begin
            fifo_rd_reg <= pop_next;
            unique case ({fifo_rd_reg, dec_flight})
                2'b10:   in_flight_reg <= in_flight_reg + 1'b1;
                2'b01:   in_flight_reg <= in_flight_reg - 1'b1;
                default: in_flight_reg <= in_flight_reg;
            endcase
        end
    end

    // Output buffer storage; cleared on reset so data_out reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) buf_mem[i] <= '0;
        end else if (write_en) begin
            buf_mem[wr_ptr_reg] <= fifo_data;
        end
    end

    // Buffer pointers and occupancy; capture plus accept leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (write_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (accept)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            unique case ({write_en, accept})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Saturating read-error counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_reg <= '0;
        end else if (fifo_rd_error && (err_count_reg != {ERR_W{1'b1}})) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
- Consumer-side controller for the team's FIFO: issues pop requests, captures returned read data, and presents it downstream on a valid/ready handshake.
- Holds data in a small local output buffer and limits outstanding pops by credit, so downstream backpressure never overflows the buffer.
- Supports a drain command that empties the FIFO and then reports completion.
- Sits between the FIFO's read side and the next pipeline stage (arbiter or serializer).

Parameters:
- BITNUMBER, 6, data word width (matches the FIFO word).
- OUT_DEPTH, 4, local output buffer entries; power of two, ≥2.
- ERR_W, 4, width of the saturating read-error counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  1 = pop whenever allowed (RUN).
- drain  in  1  1-cycle pulse: pop until the FIFO is empty, then report done.
- fifo_empty  in  1  FIFO empty flag (registered in the FIFO).
- fifo_pause  in  1  FIFO flow-control pause; no new pops while 1.
- fifo_valid_read  in  1  FIFO read data valid this cycle.
- fifo_data  in  BITNUMBER  FIFO read data, qualified by fifo_valid_read.
- fifo_rd_error  in  1  FIFO flagged a pop on empty.
- fifo_rd  out  1  pop request (registered).
- data_out  out  BITNUMBER  head-of-buffer word.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out when valid_out & ready_in.
- drain_done  out  1  1-cycle pulse at drain completion.
- busy  out  1  1 in any state except IDLE.
- err_count  out  ERR_W  saturating count of fifo_rd_error cycles.

Behaviour:
- Reset (reset=0, async): fifo_rd=0, valid_out=0, data_out=0, drain_done=0, busy=0, err_count=0, buffer pointers and count = 0, in_flight=0, state=IDLE. Deassertion takes effect at the next posedge. Reset mid-operation discards buffered and in-flight data; any fifo_valid_read in the first cycle after release is ignored.
- Credit: occupancy = buffered + in_flight. in_flight increments on each fifo_rd cycle and decrements on each fifo_valid_read cycle. Increment and decrement in the same cycle leave it unchanged.
- Pop rule: fifo_rd is registered and asserts for the next cycle only if all hold: state ∈ {RUN, DRAIN}; fifo_empty=0; fifo_pause=0; occupancy + (fifo_rd currently high) < OUT_DEPTH.
  - fifo_rd is never high two consecutive cycles. Because fifo_empty lags by one cycle, this prevents popping an emptied FIFO.
  - Pop rate is therefore at most 1 per 2 cycles.
- Capture: on fifo_valid_read, fifo_data is written at the buffer write pointer. This must never overflow; an overflow is an assertion failure in the bench.
- Output: valid_out = (buffered != 0); data_out = buffer[rd_ptr], driven combinationally from storage.
  - valid_out & ready_in advances rd_ptr.
  - A simultaneous capture and accept keep the count unchanged, including when the buffer is full or has 1 entry.
  - Pointers wrap modulo OUT_DEPTH.
- State machine:
  - IDLE: busy=0. drain → DRAIN; else enable → RUN.
  - RUN: drain → DRAIN; enable=0 → STOP.
  - STOP: no new pops. When in_flight=0 → IDLE. Buffered data still drains downstream.
  - DRAIN: pop per the pop rule regardless of enable, and ignore fifo_pause. Exit when fifo_empty=1 and in_flight=0 and fifo_rd=0 for one full cycle → DONE.
  - DONE: drain_done=1 for exactly one cycle → IDLE.
  - drain while already in DRAIN or DONE is ignored.
- Errors: err_count += 1 on each cycle with fifo_rd_error=1, saturating at 2^ERR_W−1. Cleared only by reset.
- The controller never reads fifo_data unless fifo_valid_read=1.

Test Plan:
- FIFO preloaded with 3 words (0x11, 0x22, 0x33), enable=1, ready_in=1: three fifo_rd pulses, none adjacent; data_out sequence 0x11, 0x22, 0x33; then fifo_rd stays 0 and err_count=0.
- ready_in=0, FIFO holds 8 words, OUT_DEPTH=4: exactly 4 pops, valid_out=1 holding the first word. Raise ready_in: remaining 4 words delivered in order with no loss or duplication.
- fifo_pause=1 in RUN with a non-empty FIFO: no fifo_rd. Pause=0: popping resumes within 2 cycles.
- drain pulse with FIFO holding 5 words, enable=0: 5 pops; drain_done pulses once after the last fifo_valid_read; state returns to IDLE; busy=0.
- Force fifo_rd_error high for 20 cycles with ERR_W=4: err_count saturates at 15.
- reset=0 asserted asynchronously mid-burst with 2 words buffered: all outputs 0 immediately without a clock edge; after release, valid_out=0 until new pops return.
